// File: rtl/ysyx_csr_regfile.sv
// Integer register file plus machine-mode CSR unit: GPR array with x0 tied to zero,
// CSRRW/RS/RC access, trap entry / mret sequencing and 64-bit cycle/instret counters.
module ysyx_csr_regfile #(
  parameter int              XLEN      = 32,
  parameter int              NREG      = 32,
  parameter int              NRPORT    = 2,
  parameter int              BYPASS    = 1,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0,
  parameter int              HARTID    = 0,
  localparam int             AW        = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rf_we,
  input  logic [AW-1:0]        rf_waddr,
  input  logic [XLEN-1:0]      rf_wdata,
  input  logic [NRPORT*AW-1:0] rf_raddr,
  output logic [NRPORT*XLEN-1:0] rf_rdata,
  input  logic [1:0]           csr_op,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_illegal,
  input  logic [XLEN-1:0]      pc,
  input  logic                 trap,
  input  logic [XLEN-1:0]      trap_cause,
  input  logic                 mret,
  input  logic                 instret,
  output logic [XLEN-1:0]      trap_pc,
  output logic [XLEN-1:0]      ret_pc
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

  logic [XLEN-1:0]   regs [NREG];
  logic              mie, mpie;
  logic [XLEN-1:0]   mtvec, mscratch, mepc, mcause;
  logic [2*XLEN-1:0] mcycle, minstret;

  logic [XLEN-1:0] mstatus, csr_old, csr_new, tvec_base;
  logic            csr_valid, csr_ro, csr_wen;
  logic            wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic            wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rf_we && rf_waddr != '0 && int'(rf_waddr) < NREG) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Out-of-range and x0 reads return zero; bypass forwards the in-flight write.
  for (genvar g = 0; g < NRPORT; g++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rf_raddr[g*AW +: AW];
    assign rf_rdata[g*XLEN +: XLEN] =
      (ra == '0 || int'(ra) >= NREG)          ? '0 :
      (BYPASS != 0 && rf_we && ra == rf_waddr) ? rf_wdata : regs[ra];
  end

  always_comb begin
    mstatus        = '0;
    mstatus[12:11] = 2'b11;
    mstatus[7]     = mpie;
    mstatus[3]     = mie;
  end

  always_comb begin
    csr_old   = '0;
    csr_valid = 1'b1;
    csr_ro    = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS:   csr_old = mstatus;
      ADDR_MTVEC:     csr_old = mtvec;
      ADDR_MSCRATCH:  csr_old = mscratch;
      ADDR_MEPC:      csr_old = mepc;
      ADDR_MCAUSE:    csr_old = mcause;
      ADDR_MCYCLE:    csr_old = mcycle[XLEN-1:0];
      ADDR_MCYCLEH:   csr_old = mcycle[2*XLEN-1:XLEN];
      ADDR_MINSTRET:  csr_old = minstret[XLEN-1:0];
      ADDR_MINSTRETH: csr_old = minstret[2*XLEN-1:XLEN];
      ADDR_MHARTID: begin
        csr_old = XLEN'(HARTID);
        csr_ro  = 1'b1;
      end
      default:        csr_valid = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it stays legal on read-only CSRs.
  assign csr_illegal = (csr_op != OP_NONE) &&
                       (!csr_valid || (csr_ro && (csr_op == OP_RW || csr_wdata != '0)));
  assign csr_rdata   = csr_old;

  always_comb begin
    csr_new = csr_old;
    case (csr_op)
      OP_RW:   csr_new = csr_wdata;
      OP_RS:   csr_new = csr_old | csr_wdata;
      OP_RC:   csr_new = csr_old & ~csr_wdata;
      default: csr_new = csr_old;
    endcase
  end

  assign csr_wen      = (csr_op != OP_NONE) && !csr_illegal;
  assign wr_mstatus   = csr_wen && csr_addr == ADDR_MSTATUS;
  assign wr_mtvec     = csr_wen && csr_addr == ADDR_MTVEC;
  assign wr_mscratch  = csr_wen && csr_addr == ADDR_MSCRATCH;
  assign wr_mepc      = csr_wen && csr_addr == ADDR_MEPC;
  assign wr_mcause    = csr_wen && csr_addr == ADDR_MCAUSE;
  assign wr_mcycle    = csr_wen && csr_addr == ADDR_MCYCLE;
  assign wr_mcycleh   = csr_wen && csr_addr == ADDR_MCYCLEH;
  assign wr_minstret  = csr_wen && csr_addr == ADDR_MINSTRET;
  assign wr_minstreth = csr_wen && csr_addr == ADDR_MINSTRETH;

  // Trap beats mret beats CSR write, but only on the registers the winner touches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (trap) begin
        mepc   <= pc & ~ALIGN_MASK;
        mcause <= trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end else begin
        if (mret) begin
          mie  <= mpie;
          mpie <= 1'b1;
        end else if (wr_mstatus) begin
          mie  <= csr_new[3];
          mpie <= csr_new[7];
        end
        if (wr_mepc)   mepc   <= csr_new & ~ALIGN_MASK;
        if (wr_mcause) mcause <= csr_new;
      end
      if (wr_mtvec)    mtvec    <= csr_new;
      if (wr_mscratch) mscratch <= csr_new;

      if (wr_mcycle)       mcycle[XLEN-1:0]        <= csr_new;
      else if (wr_mcycleh) mcycle[2*XLEN-1:XLEN]   <= csr_new;
      else                 mcycle                  <= mcycle + 1'b1;

      if (wr_minstret)       minstret[XLEN-1:0]      <= csr_new;
      else if (wr_minstreth) minstret[2*XLEN-1:XLEN] <= csr_new;
      else if (instret)      minstret                <= minstret + 1'b1;
    end
  end

  assign tvec_base = mtvec & ~ALIGN_MASK;
  assign trap_pc   = (mtvec[1:0] == 2'b01 && trap_cause[XLEN-1]) ?
                     tvec_base + {trap_cause[XLEN-3:0], 2'b00} : tvec_base;
  assign ret_pc    = mepc;

endmodule

// File: tb/tb_ysyx_csr_regfile.sv
// Self-checking bench for ysyx_csr_regfile: directed scenarios plus randomized GPR and
// CSR traffic compared against a simple array/arithmetic reference model.
module tb_ysyx_csr_regfile;

  logic        clk, rst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [9:0]  rf_raddr;
  logic [63:0] rf_rdata;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic [31:0] pc, trap_cause, trap_pc, ret_pc;
  logic        trap, mret, instret;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] gpr_model [32];
  logic [31:0] mscratch_model;

  ysyx_csr_regfile #(
    .XLEN(32), .NREG(32), .NRPORT(2), .BYPASS(1), .MTVEC_RST(32'h0), .HARTID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .pc(pc), .trap(trap), .trap_cause(trap_cause), .mret(mret), .instret(instret),
    .trap_pc(trap_pc), .ret_pc(ret_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rf_we = 0; rf_waddr = 0; rf_wdata = 0; rf_raddr = 0;
    csr_op = 0; csr_addr = 0; csr_wdata = 0;
    pc = 0; trap = 0; trap_cause = 0; mret = 0; instret = 0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    csr_op = 2'b00; csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w,
                        output logic [31:0] old, output logic ill);
    csr_op = op; csr_addr = a; csr_wdata = w;
    #1;
    old = csr_rdata; ill = csr_illegal;
    tick();
    csr_op = 2'b00; csr_wdata = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [11:0] addrs [7] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02};
    peek(12'h300, d);
    n_checks++;
    if (d !== 32'h0000_1800) begin
      n_fail++; $display("[TB] FAIL reset_mstatus: got %h expected %h", d, 32'h1800);
    end
    foreach (addrs[i]) begin
      peek(addrs[i], d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++; $display("[TB] FAIL reset_csr_%h: got %h expected 0", addrs[i], d);
      end
    end
    rf_raddr = {5'd5, 5'd31};
    #1;
    n_checks++;
    if (rf_rdata !== 64'h0) begin
      n_fail++; $display("[TB] FAIL reset_gpr: got %h expected 0", rf_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gpr_basic();
    rf_we = 1; rf_waddr = 5'd0; rf_wdata = 32'hDEAD; rf_raddr = {5'd0, 5'd0};
    tick();
    rf_waddr = 5'd5; rf_wdata = 32'h1234; rf_raddr = {5'd5, 5'd0};
    #1;
    n_checks++;
    if (rf_rdata[63:32] !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL gpr_bypass: got %h expected %h", rf_rdata[63:32], 32'h1234);
    end
    n_checks++;
    if (rf_rdata[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL gpr_x0_after_write: got %h expected 0", rf_rdata[31:0]);
    end
    tick();
    gpr_model[5] = 32'h1234;
    rf_we = 0; rf_raddr = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rf_rdata !== {32'h0, 32'h1234}) begin
      n_fail++; $display("[TB] FAIL gpr_x5_next_cycle: got %h expected %h", rf_rdata, {32'h0, 32'h1234});
    end
  endtask

  task automatic test_gpr_random();
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [4:0]  wa, a0, a1;
      logic [31:0] wd, e0, e1;
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a0 = 5'($urandom_range(0, 31));
      a1 = (i % 3 == 0) ? wa : 5'($urandom_range(0, 31));
      rf_we = we; rf_waddr = wa; rf_wdata = wd; rf_raddr = {a1, a0};
      e0 = (a0 == 0) ? 32'h0 : (we && a0 == wa) ? wd : gpr_model[a0];
      e1 = (a1 == 0) ? 32'h0 : (we && a1 == wa) ? wd : gpr_model[a1];
      #1;
      n_checks++;
      if (rf_rdata !== {e1, e0}) begin
        n_fail++; $display("[TB] FAIL gpr_random_%0d: got %h expected %h", i, rf_rdata, {e1, e0});
      end
      tick();
      if (we && wa != 0) gpr_model[wa] = wd;
    end
    rf_we = 0;
  endtask

  task automatic test_csr_ops();
    logic [31:0] old, d, w, model, expv;
    logic        ill;
    logic [1:0]  op;
    csr_do(2'b01, 12'h340, 32'hF0F0, old, ill);
    n_checks++;
    if (old !== 32'h0) begin n_fail++; $display("[TB] FAIL csr_rw_old: got %h expected 0", old); end
    csr_do(2'b10, 12'h340, 32'h000F, old, ill);
    n_checks++;
    if (old !== 32'hF0F0) begin n_fail++; $display("[TB] FAIL csr_rs_old: got %h expected %h", old, 32'hF0F0); end
    csr_do(2'b11, 12'h340, 32'h00F0, old, ill);
    n_checks++;
    if (old !== 32'hF0FF) begin n_fail++; $display("[TB] FAIL csr_rc_old: got %h expected %h", old, 32'hF0FF); end
    peek(12'h340, d);
    n_checks++;
    if (d !== 32'hF00F) begin n_fail++; $display("[TB] FAIL csr_final: got %h expected %h", d, 32'hF00F); end
    model = 32'hF00F;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(1, 3));
      w  = $urandom;
      csr_do(op, 12'h340, w, old, ill);
      n_checks++;
      if (old !== model || ill !== 1'b0) begin
        n_fail++; $display("[TB] FAIL csr_random_%0d: got %h/%b expected %h/0", i, old, ill, model);
      end
      model = (op == 2'b01) ? w : (op == 2'b10) ? (model | w) : (model & ~w);
    end
    mscratch_model = model;
    w = $urandom | 32'h3;
    csr_do(2'b01, 12'h341, w, old, ill);
    peek(12'h341, d);
    expv = w & 32'hFFFF_FFFC;
    n_checks++;
    if (d !== expv) begin n_fail++; $display("[TB] FAIL mepc_align: got %h expected %h", d, expv); end
  endtask

  task automatic test_illegal();
    logic [31:0] old, d;
    logic        ill;
    csr_do(2'b01, 12'hF14, 32'h5, old, ill);
    n_checks++;
    if (ill !== 1'b1 || old !== 32'h0) begin
      n_fail++; $display("[TB] FAIL hartid_rw: got ill=%b rd=%h expected ill=1 rd=0", ill, old);
    end
    csr_do(2'b10, 12'hF14, 32'h0, old, ill);
    n_checks++;
    if (ill !== 1'b0 || old !== 32'h0) begin
      n_fail++; $display("[TB] FAIL hartid_rs0: got ill=%b rd=%h expected ill=0 rd=0", ill, old);
    end
    csr_do(2'b11, 12'hF14, 32'h1, old, ill);
    n_checks++;
    if (ill !== 1'b1) begin n_fail++; $display("[TB] FAIL hartid_rc1: got ill=%b expected 1", ill); end
    csr_do(2'b01, 12'h7C0, 32'hFFFF, old, ill);
    n_checks++;
    if (ill !== 1'b1 || old !== 32'h0) begin
      n_fail++; $display("[TB] FAIL unknown_addr: got ill=%b rd=%h expected ill=1 rd=0", ill, old);
    end
    peek(12'h340, d);
    n_checks++;
    if (d !== mscratch_model) begin
      n_fail++; $display("[TB] FAIL unknown_no_change: got %h expected %h", d, mscratch_model);
    end
  endtask

  task automatic test_trap_mret();
    logic [31:0] old, d;
    logic        ill;
    csr_do(2'b10, 12'h300, 32'h8, old, ill);
    csr_do(2'b01, 12'h305, 32'h8000_1000, old, ill);
    peek(12'h300, d);
    n_checks++;
    if (d !== 32'h1808) begin n_fail++; $display("[TB] FAIL mstatus_mie_set: got %h expected %h", d, 32'h1808); end
    pc = 32'h8000_0123; trap_cause = 32'd11; trap = 1;
    #1;
    n_checks++;
    if (trap_pc !== 32'h8000_1000) begin
      n_fail++; $display("[TB] FAIL trap_pc_direct: got %h expected %h", trap_pc, 32'h80001000);
    end
    tick();
    trap = 0;
    peek(12'h341, d);
    n_checks++;
    if (d !== 32'h8000_0120) begin n_fail++; $display("[TB] FAIL trap_mepc: got %h expected %h", d, 32'h80000120); end
    peek(12'h342, d);
    n_checks++;
    if (d !== 32'd11) begin n_fail++; $display("[TB] FAIL trap_mcause: got %h expected %h", d, 32'd11); end
    peek(12'h300, d);
    n_checks++;
    if (d !== 32'h1880) begin n_fail++; $display("[TB] FAIL trap_mstatus: got %h expected %h", d, 32'h1880); end
    mret = 1;
    #1;
    n_checks++;
    if (ret_pc !== 32'h8000_0120) begin n_fail++; $display("[TB] FAIL ret_pc: got %h expected %h", ret_pc, 32'h80000120); end
    tick();
    mret = 0;
    peek(12'h300, d);
    n_checks++;
    if (d !== 32'h1888) begin n_fail++; $display("[TB] FAIL mret_mstatus: got %h expected %h", d, 32'h1888); end
    csr_do(2'b01, 12'h300, 32'h0, old, ill);
    mret = 1;
    csr_do(2'b01, 12'h300, 32'h8, old, ill);
    mret = 0;
    peek(12'h300, d);
    n_checks++;
    if (d !== 32'h1880) begin n_fail++; $display("[TB] FAIL mret_beats_csr: got %h expected %h", d, 32'h1880); end
  endtask

  task automatic test_vectored();
    logic [31:0] old, d, expv;
    logic        ill;
    logic [4:0]  c;
    csr_do(2'b01, 12'h305, 32'h8000_1001, old, ill);
    trap = 1; pc = 32'h8000_0200; trap_cause = 32'h8000_0007;
    csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h40;
    #1;
    n_checks++;
    if (trap_pc !== 32'h8000_101C || csr_illegal !== 1'b0) begin
      n_fail++; $display("[TB] FAIL trap_pc_vectored: got %h ill=%b expected %h ill=0", trap_pc, csr_illegal, 32'h8000101C);
    end
    tick();
    trap = 0; csr_op = 0;
    peek(12'h341, d);
    n_checks++;
    if (d !== 32'h8000_0200) begin n_fail++; $display("[TB] FAIL trap_beats_mepc_write: got %h expected %h", d, 32'h80000200); end
    trap_cause = 32'd2;
    #1;
    n_checks++;
    if (trap_pc !== 32'h8000_1000) begin
      n_fail++; $display("[TB] FAIL vectored_exception: got %h expected %h", trap_pc, 32'h80001000);
    end
    for (int i = 0; i < 6; i++) begin
      c = 5'($urandom_range(0, 31));
      trap_cause = {1'b1, 26'd0, c};
      expv = 32'h8000_1000 + 32'(c) * 4;
      #1;
      n_checks++;
      if (trap_pc !== expv) begin n_fail++; $display("[TB] FAIL vectored_irq_%0d: got %h expected %h", c, trap_pc, expv); end
    end
    trap = 1; pc = 32'h0000_0304; trap_cause = 32'd2;
    csr_do(2'b01, 12'h340, 32'h55, old, ill);
    trap = 0;
    peek(12'h340, d);
    n_checks++;
    if (d !== 32'h55) begin n_fail++; $display("[TB] FAIL trap_with_mscratch: got %h expected %h", d, 32'h55); end
    peek(12'h341, d);
    n_checks++;
    if (d !== 32'h304) begin n_fail++; $display("[TB] FAIL trap_with_mscratch_mepc: got %h expected %h", d, 32'h304); end
  endtask

  task automatic test_counters();
    logic [31:0] old, d, lo;
    logic        ill;
    int          cnt;
    csr_do(2'b01, 12'hB80, 32'h0, old, ill);
    csr_do(2'b01, 12'hB00, 32'hFFFF_FFFF, old, ill);
    tick();
    tick();
    peek(12'hB00, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL mcycle_wrap_lo: got %h expected 1", d); end
    peek(12'hB80, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL mcycle_wrap_hi: got %h expected 1", d); end
    peek(12'hB00, lo);
    csr_do(2'b01, 12'hB80, 32'h7, old, ill);
    peek(12'hB00, d);
    n_checks++;
    if (d !== lo) begin n_fail++; $display("[TB] FAIL mcycleh_write_holds_lo: got %h expected %h", d, lo); end
    peek(12'hB00, lo);
    repeat (5) tick();
    peek(12'hB00, d);
    n_checks++;
    if (d !== lo + 32'd5) begin n_fail++; $display("[TB] FAIL mcycle_count: got %h expected %h", d, lo + 32'd5); end
    csr_do(2'b01, 12'hB02, 32'h0, old, ill);
    csr_do(2'b01, 12'hB82, 32'h0, old, ill);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      instret = 1'($urandom_range(0, 1));
      if (instret) cnt++;
      tick();
    end
    instret = 0;
    peek(12'hB02, d);
    n_checks++;
    if (d !== 32'(cnt)) begin n_fail++; $display("[TB] FAIL minstret_count: got %h expected %h", d, 32'(cnt)); end
    instret = 1;
    csr_do(2'b01, 12'hB02, 32'd100, old, ill);
    instret = 0;
    peek(12'hB02, d);
    n_checks++;
    if (d !== 32'd100) begin n_fail++; $display("[TB] FAIL minstret_write_wins: got %h expected %h", d, 32'd100); end
    csr_do(2'b01, 12'hB82, 32'hFFFF_FFFF, old, ill);
    csr_do(2'b01, 12'hB02, 32'hFFFF_FFFF, old, ill);
    instret = 1;
    tick();
    instret = 0;
    peek(12'hB02, d);
    peek(12'hB82, lo);
    n_checks++;
    if (d !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("[TB] FAIL minstret_wrap: got %h_%h expected 0_0", lo, d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    rst = 1;
    #1;
    peek(12'hB00, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL async_mcycle: got %h expected 0", d); end
    peek(12'hB80, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL async_mcycleh: got %h expected 0", d); end
    peek(12'h340, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL async_mscratch: got %h expected 0", d); end
    rf_raddr = {5'd5, 5'd5};
    #1;
    n_checks++;
    if (rf_rdata !== 64'h0) begin n_fail++; $display("[TB] FAIL async_gpr: got %h expected 0", rf_rdata); end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    for (int i = 0; i < 32; i++) gpr_model[i] = 32'h0;
    mscratch_model = 32'h0;
    #2;
    test_reset();
    test_gpr_basic();
    test_gpr_random();
    test_csr_ops();
    test_illegal();
    test_trap_mret();
    test_vectored();
    test_counters();
    tick();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_csr_regfile.md
Name: ysyx_csr_regfile

Overview:
Parametrised integer register file plus machine-mode CSR unit for the ysyx core.
- Multi-port GPR array with x0 hardwired to zero and optional write-to-read bypass.
- Full CSRRW/CSRRS/CSRRC semantics with illegal-access detection.
- Trap entry and mret sequencing of mstatus, mepc and mcause.
- 64-bit mcycle/minstret counters.
Sits between decode (read ports, CSR ops) and writeback/commit (GPR write, trap, mret, retire).

Parameters:
XLEN, 32, data width of GPRs and CSRs (32 only for mcycleh/minstreth split; other widths are not supported).
NREG, 32, number of GPRs (16 for RV32E); AW = clog2(NREG).
NRPORT, 2, number of GPR read ports.
BYPASS, 1, 1 = a read of the register being written this cycle returns rf_wdata.
MTVEC_RST, 32'h0, reset value of mtvec.
HARTID, 0, value of mhartid.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rf_we  in  1  GPR write enable
rf_waddr  in  AW  GPR write address
rf_wdata  in  XLEN  GPR write data
rf_raddr  in  NRPORT*AW  flattened read addresses; port i at [i*AW +: AW]
rf_rdata  out  NRPORT*XLEN  flattened read data, combinational
csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR source operand
csr_rdata  out  XLEN  old CSR value, combinational
csr_illegal  out  1  combinational; unknown address, or write to read-only CSR
pc  in  XLEN  PC of the trapping instruction
trap  in  1  take trap this cycle (ecall, exception, interrupt)
trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
mret  in  1  execute mret this cycle
instret  in  1  one instruction retired this cycle
trap_pc  out  XLEN  combinational trap target
ret_pc  out  XLEN  combinational, equals mepc

Behaviour:
- Reset (async, immediate on rst rising; no clock needed):
  - All GPRs = 0.
  - mstatus: MIE=0, MPIE=0, MPP=2'b11 (fixed).
  - mtvec = MTVEC_RST.
  - mepc, mcause, mscratch, mcycle, minstret = 0.
- GPR:
  - Reads are combinational.
  - Write occurs at posedge when rf_we is high and rf_waddr != 0; writes to x0 are dropped and x0 always reads 0.
  - BYPASS=1 and raddr==waddr!=0 with rf_we: rdata = rf_wdata in the same cycle.
  - BYPASS=0: rdata shows the old value until the next edge.
  - rf_waddr >= NREG: write ignored, read returns 0.
- CSR map:
  - 0x300 mstatus (only bits 3, 7 writable; MPP reads 11).
  - 0x305 mtvec.
  - 0x340 mscratch.
  - 0x341 mepc (bits[1:0] forced 0 on write).
  - 0x342 mcause.
  - 0xB00 / 0xB80 mcycle low/high.
  - 0xB02 / 0xB82 minstret low/high.
  - 0xF14 mhartid (read-only).
- CSR operations:
  - New value: RW = wdata; RS = old|wdata; RC = old&~wdata. Committed at posedge when csr_op != 0 and csr_illegal=0.
  - csr_rdata returns the pre-write value; unknown address reads 0.
  - Unknown address with any op: csr_illegal=1, no state change.
  - Write to 0xF14 with op RW, or RS/RC with wdata != 0: csr_illegal=1, no state change.
  - RS/RC to 0xF14 with wdata==0: legal read.
- Trap (posedge, trap=1):
  - mepc <= {pc[XLEN-1:2],2'b00}; mcause <= trap_cause; MPIE <= MIE; MIE <= 0.
  - trap_pc = {mtvec[XLEN-1:2],2'b00} when mtvec[1:0]==00, or when the cause is not an interrupt.
  - trap_pc = base + 4*cause[XLEN-2:0] when mtvec[1:0]==01 and cause is an interrupt.
- mret (posedge): MIE <= MPIE; MPIE <= 1. ret_pc = mepc (combinational).
- Simultaneous events, priority trap > mret > CSR write:
  - The lower-priority state update is discarded for registers the higher one touches.
  - A CSR write to an untouched CSR still commits. Example: trap + write to mscratch commits both.
- Counters:
  - mcycle increments every cycle out of reset.
  - minstret increments when instret=1.
  - 64-bit wrap from all-ones to 0.
  - A CSR write to either half in a cycle replaces that cycle's increment for the whole counter: written half takes the new value, other half holds.
- Latency: all writes are visible on the read side the cycle after the edge.

Test Plan:
- Reset, write x0=0xDEAD, write x5=0x1234 -> x0 reads 0, x5 reads 0x1234 next cycle; with BYPASS=1, port1 reads 0x1234 in the write cycle.
- mscratch RW 0xF0F0, RS 0x000F, RC 0x00F0 -> rdata sequence 0, 0xF0F0, 0xF0FF; final value 0xF00F.
- Write 0xF14 via RW -> csr_illegal=1, reads HARTID; access 0x7C0 -> illegal, rdata 0, no state change.
- mstatus MIE=1, mtvec=0x80001000, trap with pc=0x80000123, cause=11 -> trap_pc 0x80001000, mepc 0x80000120, mcause 11, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1, ret_pc 0x80000120.
- mtvec=0x80001001, trap cause 0x80000007 -> trap_pc 0x8000101C; same cycle RW mepc=0x40 -> mepc = trapping pc, not 0x40.
- Write mcycle=0xFFFFFFFF, then run 2 cycles -> mcycleh=1, mcycle=1; assert rst mid-run without a clock edge -> all counters 0 immediately.
